cnu_min2_acc: RTL and testbench



---
 rtl/cnu_pkg.sv | 36 +++
 rtl/cnu_min2_tree.sv | 77 +++++++
 rtl/cnu_min2_acc.sv | 201 ++++++++++++++++++++
 tb/tb_cnu_min2_acc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// ---------------------------------------------------------------------------
// cnu_pkg
//
// Shared definitions for the min-sum check-node accumulator:
//   - default widths of the magnitude, lane count and row-global index
//   - CNU_SENTINEL: all-ones magnitude meaning "no message seen yet"
//   - cnu_result_t: one emitted row result (min1, min2, idx, sign, err)
//   - cnu_sat_sub: subtraction that clamps at zero, used for the optional
//     offset-min-sum correction
// ---------------------------------------------------------------------------
package cnu_pkg;

    localparam int CNU_DATA_W = 9;
    localparam int CNU_LANES  = 4;
    localparam int CNU_IDX_W  = 5;

    // An empty slot compares larger than or equal to any real message
    localparam logic [CNU_DATA_W-1:0] CNU_SENTINEL = '1;

    typedef struct packed {
        logic [CNU_DATA_W-1:0] min1;
        logic [CNU_DATA_W-1:0] min2;
        logic [CNU_IDX_W-1:0]  idx;
        logic                  sign;
        logic                  err;
    } cnu_result_t;

    // Offset-min-sum correction: never wraps below zero
    function automatic logic [CNU_DATA_W-1:0] cnu_sat_sub(
        input logic [CNU_DATA_W-1:0] value,
        input logic [CNU_DATA_W-1:0] offset
    );
        return (value > offset) ? (value - offset) : '0;
    endfunction

endpackage

// File: rtl/cnu_min2_tree.sv
// ---------------------------------------------------------------------------
// cnu_min2_tree
//
// Combinational finder for the smallest and second-smallest magnitude among
// the unmasked lanes of one input beat, plus the index of the smallest one
// and the XOR of the unmasked sign bits.
//
// Ports:
//   i_mag    DATA_W*LANES  lane k magnitude at [k*DATA_W +: DATA_W]
//   i_sign   LANES         lane sign bits
//   i_mask   LANES         lane enables; a masked lane reads as all-ones and
//                          contributes no sign
//   i_base   IDX_W         row-global index of lane 0 in this beat
//   o_min1   DATA_W        smallest magnitude
//   o_min2   DATA_W        second-smallest magnitude
//   o_idx    IDX_W         i_base + lane of o_min1
//   o_sign   1             XOR of unmasked signs
// ---------------------------------------------------------------------------
module cnu_min2_tree #(
    parameter int DATA_W = 9,
    parameter int LANES  = 4,
    parameter int IDX_W  = 5
) (
    input  logic [DATA_W*LANES-1:0] i_mag,
    input  logic [LANES-1:0]        i_sign,
    input  logic [LANES-1:0]        i_mask,
    input  logic [IDX_W-1:0]        i_base,
    output logic [DATA_W-1:0]       o_min1,
    output logic [DATA_W-1:0]       o_min2,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_sign
);

    localparam int LANE_W = $clog2(LANES);

    logic [DATA_W-1:0] w_min1;
    logic [DATA_W-1:0] w_min2;
    logic [LANE_W-1:0] w_lane;

    // Heap-ordered binary reduction: node n combines node 2n (lower lanes)
    // with node 2n+1 (higher lanes); leaves sit at LANES..2*LANES-1.
    // The higher-lane child only wins on strictly smaller magnitude, so on a
    // tie the lower lane keeps min1 and the equal value becomes min2.
    function automatic logic [2*DATA_W+LANE_W-1:0] findMinPair(
        input logic [DATA_W*LANES-1:0] mag,
        input logic [LANES-1:0]        mask
    );
        logic [DATA_W-1:0] m1 [1:2*LANES-1];
        logic [DATA_W-1:0] m2 [1:2*LANES-1];
        logic [LANE_W-1:0] ix [1:2*LANES-1];
        for (int k = 0; k < LANES; k++) begin
            m1[LANES+k] = mask[k] ? mag[k*DATA_W +: DATA_W] : '1;
            m2[LANES+k] = '1;
            ix[LANES+k] = LANE_W'(k);
        end
        for (int n = LANES - 1; n >= 1; n--) begin
            if (m1[2*n+1] < m1[2*n]) begin
                m1[n] = m1[2*n+1];
                ix[n] = ix[2*n+1];
                m2[n] = (m1[2*n] < m2[2*n+1]) ? m1[2*n] : m2[2*n+1];
            end else begin
                m1[n] = m1[2*n];
                ix[n] = ix[2*n];
                m2[n] = (m1[2*n+1] < m2[2*n]) ? m1[2*n+1] : m2[2*n];
            end
        end
        return {m1[1], m2[1], ix[1]};
    endfunction

    assign {w_min1, w_min2, w_lane} = findMinPair(i_mag, i_mask);

    assign o_min1 = w_min1;
    assign o_min2 = w_min2;
    assign o_idx  = i_base + IDX_W'(w_lane);
    assign o_sign = ^(i_sign & i_mask);

endmodule

// File: rtl/cnu_min2_acc.sv
// ---------------------------------------------------------------------------
// cnu_min2_acc
//
// Streaming min-sum check-node accumulator. A check row arrives as one or
// more beats of LANES sign/magnitude messages; the block tracks min1, its
// row-global index, min2 and the XOR of signs, and on the last beat emits
// one result through a valid/ready output register.
//
// Optional feature: define CNU_OFFSET_EN to subtract OFFSET (clamped at 0)
// from both output minima. Without it the raw minima are emitted.
//
// Ports:
//   clk        1             clock, rising edge
//   rst_n      1             asynchronous active-low reset
//   in_valid   1             beat valid
//   in_ready   1             beat accepted when in_valid & in_ready
//   in_mag     DATA_W*LANES  lane k at [k*DATA_W +: DATA_W]
//   in_sign    LANES         lane sign bits
//   in_mask    LANES         lane enables
//   in_last    1             final beat of the row
//   out_valid  1             result valid
//   out_ready  1             result consumed when out_valid & out_ready
//   out_min1   DATA_W        smallest magnitude
//   out_min2   DATA_W        second-smallest magnitude
//   out_idx    IDX_W         row-global index of min1
//   out_sign   1             XOR of unmasked signs
//   out_err    1             row ran past 2^IDX_W/LANES beats
// ---------------------------------------------------------------------------
module cnu_min2_acc
    import cnu_pkg::*;
#(
    parameter int DATA_W = CNU_DATA_W,
    parameter int LANES  = CNU_LANES,
    parameter int IDX_W  = CNU_IDX_W,
    parameter int OFFSET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W*LANES-1:0] in_mag,
    input  logic [LANES-1:0]        in_sign,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_min1,
    output logic [DATA_W-1:0]       out_min2,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_sign,
    output logic                    out_err
);

    localparam int LANE_W   = $clog2(LANES);
    localparam int BEAT_MAX = (2 ** IDX_W) / LANES;
    localparam int BEAT_W   = $clog2(BEAT_MAX + 1);

`ifdef CNU_OFFSET_EN
    localparam int EFF_OFFSET = OFFSET;
`else
    localparam int EFF_OFFSET = 0;
`endif

    // Accumulator for the row in progress
    logic [DATA_W-1:0] r_acc_min1;
    logic [DATA_W-1:0] r_acc_min2;
    logic [IDX_W-1:0]  r_acc_idx;
    logic              r_acc_sign;
    logic [BEAT_W-1:0] r_beat;
    logic              r_err;

    // Output register
    cnu_result_t       r_out;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_saturated;
    logic [IDX_W-1:0]  w_base;
    logic [DATA_W-1:0] w_loc_min1;
    logic [DATA_W-1:0] w_loc_min2;
    logic [IDX_W-1:0]  w_loc_idx;
    logic              w_loc_sign;
    logic              w_local_wins;
    logic [DATA_W-1:0] w_new_min1;
    logic [DATA_W-1:0] w_new_min2;
    logic [IDX_W-1:0]  w_new_idx;
    logic              w_new_sign;
    logic              w_new_err;
    cnu_result_t       w_result;

    // The input stalls only while a finished result is still unconsumed
    assign in_ready    = !(r_out_valid && !out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_saturated = (r_beat == BEAT_W'(BEAT_MAX));

    // Lane 0 of beat b has global index b*LANES; past saturation the index
    // wraps, which is acceptable because overflowing rows are flagged.
    assign w_base = IDX_W'(r_beat) << LANE_W;

    cnu_min2_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .IDX_W  (IDX_W)
    ) u_tree (
        .i_mag  (in_mag),
        .i_sign (in_sign),
        .i_mask (in_mask),
        .i_base (w_base),
        .o_min1 (w_loc_min1),
        .o_min2 (w_loc_min2),
        .o_idx  (w_loc_idx),
        .o_sign (w_loc_sign)
    );

    // Merge the beat into the accumulator. The accumulator holds earlier
    // indices, so the beat only takes min1 on strictly smaller magnitude.
    // min2 is the smallest of the three values left after picking min1:
    // when the beat wins, acc_min1 <= acc_min2 so only acc_min1 and the
    // beat's min2 matter; otherwise only acc_min2 and the beat's min1 do.
    assign w_local_wins = (w_loc_min1 < r_acc_min1);
    assign w_new_min1   = w_local_wins ? w_loc_min1 : r_acc_min1;
    assign w_new_idx    = w_local_wins ? w_loc_idx  : r_acc_idx;
    assign w_new_min2   = w_local_wins
                        ? ((r_acc_min1 < w_loc_min2) ? r_acc_min1 : w_loc_min2)
                        : ((w_loc_min1 < r_acc_min2) ? w_loc_min1 : r_acc_min2);
    assign w_new_sign   = r_acc_sign ^ w_loc_sign;

    // An overflowing last beat must still be reported with its own row
    assign w_new_err    = r_err || w_saturated;

    // Record loaded into the output register on an accepted last beat;
    // the offset applies to the sentinel as well
    always_comb begin
        w_result      = '0;
        w_result.min1 = cnu_sat_sub(w_new_min1, DATA_W'(EFF_OFFSET));
        w_result.min2 = cnu_sat_sub(w_new_min2, DATA_W'(EFF_OFFSET));
        w_result.idx  = w_new_idx;
        w_result.sign = w_new_sign;
        w_result.err  = w_new_err;
    end

    // Accumulator, beat counter and sticky overflow flag. An accepted last
    // beat reinitialises everything so the next row can start immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_min1 <= CNU_SENTINEL;
            r_acc_min2 <= CNU_SENTINEL;
            r_acc_idx  <= '0;
            r_acc_sign <= 1'b0;
            r_beat     <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc_min1 <= CNU_SENTINEL;
                r_acc_min2 <= CNU_SENTINEL;
                r_acc_idx  <= '0;
                r_acc_sign <= 1'b0;
                r_beat     <= '0;
                r_err      <= 1'b0;
            end else begin
                r_acc_min1 <= w_new_min1;
                r_acc_min2 <= w_new_min2;
                r_acc_idx  <= w_new_idx;
                r_acc_sign <= w_new_sign;
                r_err      <= w_new_err;
                if (!w_saturated) begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    // Output register: loads on an accepted last beat, holds while stalled,
    // and drops valid on a consume with nothing new arriving. A consume and
    // a new load in the same cycle keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out.min1  <= CNU_SENTINEL;
            r_out.min2  <= CNU_SENTINEL;
            r_out.idx   <= '0;
            r_out.sign  <= 1'b0;
            r_out.err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && in_last) begin
                r_out       <= w_result;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_min1  = r_out.min1;
    assign out_min2  = r_out.min2;
    assign out_idx   = r_out.idx;
    assign out_sign  = r_out.sign;
    assign out_err   = r_out.err;

endmodule

// File: tb/tb_cnu_min2_acc.sv
// Directed bench for cnu_min2_acc: beats are driven one cycle at a time,
// a behavioural row model predicts each result and queues it, and a monitor
// pops and compares whenever the DUT hands a result over.
module tb_cnu_min2_acc;

   localparam int DW  = 9;
   localparam int LN  = 4;
   localparam int IW  = 5;
   localparam int OFF = 2;
   localparam int ONES = (1 << DW) - 1;
   localparam int MAX_BEATS = (1 << IW) / LN;

   typedef struct {
      int min1;
      int min2;
      int idx;
      int sign;
      int err;
   } expect_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [DW*LN-1:0] inMag = '0;
   logic [LN-1:0]    inSign = '0;
   logic [LN-1:0]    inMask = '0;
   logic             inLast = 1'b0;
   logic             outValid;
   logic             outReady = 1'b1;
   logic [DW-1:0]    outMin1;
   logic [DW-1:0]    outMin2;
   logic [IW-1:0]    outIdx;
   logic             outSign;
   logic             outErr;

   expect_t scoreboard[$];
   int      rowMag[$];
   int      rowIdx[$];
   int      rowSign = 0;
   int      rowBeats = 0;
   int      nVectors = 0;
   int      nMiscompares = 0;

   cnu_min2_acc #(
      .DATA_W (DW),
      .LANES  (LN),
      .IDX_W  (IW),
      .OFFSET (OFF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_mag    (inMag),
      .in_sign   (inSign),
      .in_mask   (inMask),
      .in_last   (inLast),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_min1  (outMin1),
      .out_min2  (outMin2),
      .out_idx   (outIdx),
      .out_sign  (outSign),
      .out_err   (outErr)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case something never handshakes
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nVectors++;
      assert (observed === expected)
      else begin
         nMiscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int applyOffset(input int v);
`ifdef CNU_OFFSET_EN
      return (v > OFF) ? v - OFF : 0;
`else
      return v;
`endif
   endfunction

   task automatic clearRow();
      rowMag.delete();
      rowIdx.delete();
      rowSign  = 0;
      rowBeats = 0;
   endtask

   // Reference row model: min1 is the first occurrence of the minimum over
   // the whole row, min2 the minimum of every other message
   task automatic modelAccept(input int mv[4], input logic [3:0] sg,
                              input logic [3:0] mk, input logic lst);
      expect_t e;
      int      pos;
      for (int k = 0; k < LN; k++) begin
         if (mk[k]) begin
            rowMag.push_back(mv[k]);
            rowIdx.push_back(rowBeats * LN + k);
            rowSign ^= int'(sg[k]);
         end
      end
      rowBeats++;
      if (lst) begin
         e.min1 = ONES;
         e.idx  = 0;
         pos    = -1;
         foreach (rowMag[i]) begin
            if (rowMag[i] < e.min1) begin
               e.min1 = rowMag[i];
               e.idx  = rowIdx[i] % (1 << IW);
               pos    = i;
            end
         end
         e.min2 = ONES;
         foreach (rowMag[i]) begin
            if (i != pos && rowMag[i] < e.min2) e.min2 = rowMag[i];
         end
         e.min1 = applyOffset(e.min1);
         e.min2 = applyOffset(e.min2);
         e.sign = rowSign;
         e.err  = (rowBeats > MAX_BEATS) ? 1 : 0;
         scoreboard.push_back(e);
         clearRow();
      end
   endtask

   // Drives one beat (called just after a rising edge) and returns just
   // after the edge on which it was accepted
   task automatic applyStimulus(input int m0, input int m1, input int m2,
                                input int m3, input logic [3:0] sg,
                                input logic [3:0] mk, input logic lst);
      int mv[4];
      int waitCnt;
      mv      = '{m0, m1, m2, m3};
      inMag   = {DW'(m3), DW'(m2), DW'(m1), DW'(m0)};
      inSign  = sg;
      inMask  = mk;
      inLast  = lst;
      inValid = 1'b1;
      waitCnt = 0;
      while (!inReady && waitCnt < 200) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!inReady) begin
         checkOutput("in_ready_timeout", {31'd0, inReady}, 32'd1);
         inValid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      modelAccept(mv, sg, mk, lst);
   endtask

   task automatic waitDrain();
      int cnt = 0;
      while (scoreboard.size() != 0 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput("scoreboard_drain", scoreboard.size(), 32'd0);
   endtask

   // Monitor: a result is consumed on the next rising edge whenever valid
   // and ready are both high at the falling edge
   always @(negedge clk) begin
      expect_t e;
      if (rst_n && outValid && outReady) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected_result", scoreboard.size(), 32'd1);
         end else begin
            e = scoreboard.pop_front();
            checkOutput("min1", outMin1, e.min1);
            checkOutput("min2", outMin2, e.min2);
            checkOutput("idx",  outIdx,  e.idx);
            checkOutput("sign", outSign, e.sign);
            checkOutput("err",  outErr,  e.err);
         end
      end
   end

   initial begin
      int pending[4];
      $display("[TB] cnu_min2_acc bench start");
      clearRow();

      // Reset state while rst_n is low
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", outValid, 32'd0);
      checkOutput("reset_out_min1", outMin1, ONES);
      checkOutput("reset_out_min2", outMin2, ONES);
      checkOutput("reset_out_idx", outIdx, 32'd0);
      checkOutput("reset_out_sign", outSign, 32'd0);
      checkOutput("reset_out_err", outErr, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_in_ready", inReady, 32'd1);

      // Single beat row, result one cycle after acceptance
      applyStimulus(3, 7, 1, 5, 4'b0101, 4'b1111, 1'b1);
      checkOutput("latency_out_valid", outValid, 32'd1);

      // Two-beat row with a tie between lanes 4 and 6
      applyStimulus(10, 9, 8, 7, 4'b0001, 4'b1111, 1'b0);
      applyStimulus(6, 20, 6, 30, 4'b0110, 4'b1111, 1'b1);

      // Masked lanes contribute neither magnitude nor sign
      applyStimulus(9, 9, 9, 9, 4'b0011, 4'b1111, 1'b0);
      applyStimulus(2, 0, 0, 0, 4'b1110, 4'b0001, 1'b1);

      // Empty row and single-message row keep the sentinels
      applyStimulus(1, 2, 3, 4, 4'b1111, 4'b0000, 1'b1);
      applyStimulus(8, 5, 1, 1, 4'b0100, 4'b0100, 1'b1);

      // Nine beats overflow the counter; the following row is clean
      for (int b = 0; b <= MAX_BEATS; b++) begin
         applyStimulus(20 + b, 30, 40, 50, 4'b0000, 4'b1111, (b == MAX_BEATS));
      end
      applyStimulus(7, 8, 9, 10, 4'b1000, 4'b1111, 1'b1);
      waitDrain();

      // Back-pressure: result held stable and input stalled
      outReady = 1'b0;
      applyStimulus(12, 11, 13, 14, 4'b0001, 4'b1111, 1'b1);
      checkOutput("stall_in_ready", inReady, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checkOutput("stall_out_valid", outValid, 32'd1);
         checkOutput("stall_min1", outMin1, scoreboard[0].min1);
         checkOutput("stall_idx", outIdx, scoreboard[0].idx);
      end
      // Next row's last beat waits, then goes in on the consume cycle
      pending = '{33, 31, 32, 35};
      inMag   = {DW'(35), DW'(32), DW'(31), DW'(33)};
      inSign  = 4'b0011;
      inMask  = 4'b1111;
      inLast  = 1'b1;
      inValid = 1'b1;
      @(posedge clk); #1;
      checkOutput("pending_in_ready", inReady, 32'd0);
      outReady = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      modelAccept(pending, 4'b0011, 4'b1111, 1'b1);
      checkOutput("consume_load_out_valid", outValid, 32'd1);
      waitDrain();

      // Back-to-back random rows
      for (int r = 0; r < 6; r++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            applyStimulus($urandom_range(0, ONES), $urandom_range(0, ONES),
                          $urandom_range(0, 15), $urandom_range(0, ONES),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          (b == nb - 1));
         end
      end
      waitDrain();

      // Reset mid-row discards the partial row
      applyStimulus(0, 0, 0, 0, 4'b1111, 4'b1111, 1'b0);
      applyStimulus(0, 0, 0, 0, 4'b1111, 4'b1111, 1'b0);
      rst_n = 1'b0;
      clearRow();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checkOutput("midreset_out_valid", outValid, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(40, 30, 50, 60, 4'b0010, 4'b1111, 1'b1);
      waitDrain();

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
